// File: rtl/mips_alu_pkg.sv
// Shared encodings for the ID/EX operand stage: alu_32 select codes, MIPS opcode/funct
// values and the immediate-extension kind.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_EQ  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode/funct decode into the alu_32 select, immediate extension kind,
// whether B comes from rt, and an illegal-instruction flag.
module alu_ctrl_dec
    import mips_alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_sel,
    output ext_e       ext,
    output logic       use_rt,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_ADD;
        ext     = EXT_SIGN;
        use_rt  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt = 1'b1;
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_NOR:  alu_sel = ALU_NOR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: alu_sel = ALU_ADD;
            OP_SLTI: alu_sel = ALU_SLT;
            OP_ANDI: begin
                alu_sel = ALU_AND;
                ext     = EXT_ZERO;
            end
            OP_ORI: begin
                alu_sel = ALU_OR;
                ext     = EXT_ZERO;
            end
            OP_LW, OP_SW: alu_sel = ALU_ADD;
            OP_BEQ: begin
                alu_sel = ALU_EQ;
                use_rt  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding alu_32: decode, operand build, RAW bypass, load-use stall.
// ID_EX_FWD_EN enables the bypass network; without it any pending writer of a source stalls.
module id_ex_operand_stage
    import mips_alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [15:0]   id_imm16,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic [DW-1:0] alu_result,
    input  logic          exmem_wr,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_wr,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [DW-1:0] A_in,
    output logic [DW-1:0] B_in,
    output logic [3:0]    ALU_Sel,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_illegal
);

    logic [3:0] dec_sel;
    ext_e       dec_ext;
    logic       dec_use_rt;
    logic       dec_illegal;

    alu_ctrl_dec u_dec (
        .opcode  (id_opcode),
        .funct   (id_funct),
        .alu_sel (dec_sel),
        .ext     (dec_ext),
        .use_rt  (dec_use_rt),
        .illegal (dec_illegal)
    );

    // $0 is hardwired zero, so it never matches a writer.
    function automatic logic src_match(input logic [RW-1:0] src, input logic wv,
                                       input logic [RW-1:0] wrd);
        return (src != '0) && wv && (wrd == src);
    endfunction

    logic ex_wr_v;
    logic rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;

    assign ex_wr_v = ex_valid & ex_reg_write;
    assign rs_ex   = src_match(id_rs, ex_wr_v, ex_rd);
    assign rs_mem  = src_match(id_rs, exmem_wr, exmem_rd);
    assign rs_wb   = src_match(id_rs, memwb_wr, memwb_rd);
    assign rt_ex   = src_match(id_rt, ex_wr_v, ex_rd);
    assign rt_mem  = src_match(id_rt, exmem_wr, exmem_rd);
    assign rt_wb   = src_match(id_rt, memwb_wr, memwb_rd);

    logic [DW-1:0] imm_ext;
    assign imm_ext = (dec_ext == EXT_ZERO) ? {{(DW-16){1'b0}}, id_imm16}
                                           : {{(DW-16){id_imm16[15]}}, id_imm16};

    logic          hazard;
    logic [DW-1:0] rs_val, rt_val;

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be bypassed: its data does not exist yet.
    assign hazard = ex_valid & ex_mem_read & (rs_ex | (dec_use_rt & rt_ex));
    assign rs_val = rs_ex ? alu_result : rs_mem ? exmem_data : rs_wb ? memwb_data : id_rs_data;
    assign rt_val = rt_ex ? alu_result : rt_mem ? exmem_data : rt_wb ? memwb_data : id_rt_data;
`else
    logic unused_bypass_data;
    assign unused_bypass_data = ^{alu_result, exmem_data, memwb_data};
    assign hazard = rs_ex | rs_mem | rs_wb | (dec_use_rt & (rt_ex | rt_mem | rt_wb));
    assign rs_val = id_rs_data;
    assign rt_val = id_rt_data;
`endif

    logic advance, transfer;
    assign advance  = !ex_valid | ex_ready;
    assign id_ready = advance & !hazard & !flush;
    assign transfer = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            A_in         <= '0;
            B_in         <= '0;
            ALU_Sel      <= ALU_ADD;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            if (flush)
                ex_valid <= 1'b0;
            else if (advance)
                ex_valid <= id_valid & !hazard;
            if (transfer) begin
                A_in         <= rs_val;
                B_in         <= dec_use_rt ? rt_val : imm_ext;
                ALU_Sel      <= dec_sel;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write & !dec_illegal;
                ex_mem_read  <= id_mem_read;
                ex_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with a scoreboard queue of expected EX contents.
module tb_id_ex_operand_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, id_valid, id_ready;
    logic [5:0]  id_opcode, id_funct;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic        id_reg_write, id_mem_read;
    logic [31:0] alu_result;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic        ex_ready, ex_valid;
    logic [31:0] A_in, B_in;
    logic [3:0]  ALU_Sel;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_illegal;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t q[$];

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_imm16(id_imm16),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .alu_result(alu_result),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .A_in(A_in), .B_in(B_in), .ALU_Sel(ALU_Sel),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.rd = rd; e.rw = rw; e.mr = mr; e.ill = ill;
        return e;
    endfunction

    task automatic id(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                      input logic [31:0] rtd, input logic [4:0] rd, input logic rw,
                      input logic mr);
        id_valid = 1'b1; id_opcode = op; id_funct = fn; id_imm16 = imm;
        id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    // One clock: check id_ready, update the scoreboard, then check EX contents after the edge.
    task automatic tick(input string tag, input logic exp_rdy, input exp_t e);
        #1;
        chk({tag, ".id_ready"}, {31'd0, id_ready}, {31'd0, exp_rdy});
        if (flush)
            q.delete();
        else if (q.size() > 0 && ex_ready)
            void'(q.pop_front());
        if (id_valid && exp_rdy)
            q.push_back(e);
        @(posedge clk);
        #1;
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk({tag, ".A_in"}, A_in, q[0].a);
            chk({tag, ".B_in"}, B_in, q[0].b);
            chk({tag, ".ALU_Sel"}, {28'd0, ALU_Sel}, {28'd0, q[0].sel});
            chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, q[0].rd});
            chk({tag, ".ctrl"}, {29'd0, ex_reg_write, ex_mem_read, ex_illegal},
                {29'd0, q[0].rw, q[0].mr, q[0].ill});
        end
    endtask

    exp_t none;

    initial begin
        none = mk(32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 0; ex_ready = 1; alu_result = 0;
        exmem_wr = 0; exmem_rd = 0; exmem_data = 0;
        memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
        reset = 1;
        id(6'h00, 6'h20, 16'h0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst.A_in", A_in, 32'd0);
            chk("rst.B_in", B_in, 32'd0);
            chk("rst.ALU_Sel", {28'd0, ALU_Sel}, 32'h2);
            chk("rst.ctrl", {26'd0, ex_rd, ex_reg_write}, 32'd0);
        end
        reset = 0;

        // add $3,$1,$2
        tick("add", 1'b1, mk(32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0));
        // andi zero-extends, addi sign-extends the same immediate
        id(6'h0C, 6'h00, 16'h8001, 5'd1, 5'd4, 32'd5, 32'd0, 5'd4, 1'b1, 1'b0);
        tick("andi", 1'b1, mk(32'd5, 32'h0000_8001, 4'b0000, 5'd4, 1'b1, 1'b0, 1'b0));
        id(6'h08, 6'h00, 16'h8001, 5'd1, 5'd6, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0);
        tick("addi", 1'b1, mk(32'd5, 32'hFFFF_8001, 4'b0010, 5'd6, 1'b1, 1'b0, 1'b0));

        // add $3 then sub $4,$3,$1 with $3 pending in EX and EX/MEM
        id(6'h00, 6'h20, 16'h0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        tick("add2", 1'b1, mk(32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0));
        id(6'h00, 6'h22, 16'h0, 5'd3, 5'd1, 32'h33, 32'd5, 5'd4, 1'b1, 1'b0);
        alu_result = 32'd9; exmem_wr = 1; exmem_rd = 5'd3; exmem_data = 32'h77;
`ifdef ID_EX_FWD_EN
        tick("sub_fwd", 1'b1, mk(32'd9, 32'd5, 4'b0110, 5'd4, 1'b1, 1'b0, 1'b0));
        exmem_wr = 0;
`else
        tick("sub_stall_ex", 1'b0, none);
        tick("sub_stall_mem", 1'b0, none);
        exmem_wr = 0;
        tick("sub_rf", 1'b1, mk(32'h33, 32'd5, 4'b0110, 5'd4, 1'b1, 1'b0, 1'b0));
`endif

        // lw $3 then add $5,$3,$3: load-use bubble
        id(6'h23, 6'h00, 16'h0004, 5'd1, 5'd3, 32'd5, 32'd0, 5'd3, 1'b1, 1'b1);
        tick("lw", 1'b1, mk(32'd5, 32'd4, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0));
        id(6'h00, 6'h20, 16'h0, 5'd3, 5'd3, 32'h11, 32'h11, 5'd5, 1'b1, 1'b0);
        tick("lu_bubble", 1'b0, none);
        exmem_wr = 1; exmem_rd = 5'd3; exmem_data = 32'hABCD;
`ifdef ID_EX_FWD_EN
        tick("lu_fwd", 1'b1, mk(32'hABCD, 32'hABCD, 4'b0010, 5'd5, 1'b1, 1'b0, 1'b0));
        exmem_wr = 0;
`else
        tick("lu_stall_mem", 1'b0, none);
        exmem_wr = 0;
        tick("lu_rf", 1'b1, mk(32'h11, 32'h11, 4'b0010, 5'd5, 1'b1, 1'b0, 1'b0));
`endif

        // EX stalled three cycles, flush in the second
        id(6'h0D, 6'h00, 16'h00F0, 5'd1, 5'd7, 32'd5, 32'd0, 5'd7, 1'b1, 1'b0);
        ex_ready = 0;
        tick("stall1", 1'b0, none);
        flush = 1;
        tick("flush", 1'b0, none);
        flush = 0; id_valid = 0;
        tick("stall3", 1'b1, none);
        ex_ready = 1;

        // unknown opcode, beq, slt
        id(6'h3F, 6'h00, 16'h1234, 5'd1, 5'd2, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0);
        tick("illegal", 1'b1, mk(32'd5, 32'h1234, 4'b0010, 5'd8, 1'b0, 1'b0, 1'b1));
        id(6'h04, 6'h00, 16'h0010, 5'd1, 5'd2, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
        tick("beq", 1'b1, mk(32'd5, 32'd7, 4'b1111, 5'd0, 1'b0, 1'b0, 1'b0));
        id(6'h00, 6'h2A, 16'h0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0);
        tick("slt", 1'b1, mk(32'd5, 32'd7, 4'b0111, 5'd9, 1'b1, 1'b0, 1'b0));

        // $0 never matches a writer
        id(6'h00, 6'h20, 16'h0, 5'd0, 5'd2, 32'd0, 32'd7, 5'd8, 1'b1, 1'b0);
        exmem_wr = 1; exmem_rd = 5'd0; exmem_data = 32'hDEAD;
        memwb_wr = 1; memwb_rd = 5'd0; memwb_data = 32'hBEEF;
        tick("zero_reg", 1'b1, mk(32'd0, 32'd7, 4'b0010, 5'd8, 1'b1, 1'b0, 1'b0));

        // or $10,$2,$1 with $2 in MEM/WB and $1 in EX/MEM
        id(6'h00, 6'h25, 16'h0, 5'd2, 5'd1, 32'h1, 32'h2, 5'd10, 1'b1, 1'b0);
        exmem_rd = 5'd1; exmem_data = 32'h66;
        memwb_rd = 5'd2; memwb_data = 32'h55;
`ifdef ID_EX_FWD_EN
        tick("or_fwd", 1'b1, mk(32'h55, 32'h66, 4'b0001, 5'd10, 1'b1, 1'b0, 1'b0));
`else
        tick("or_stall", 1'b0, none);
        exmem_wr = 0; memwb_wr = 0;
        tick("or_rf", 1'b1, mk(32'h1, 32'h2, 4'b0001, 5'd10, 1'b1, 1'b0, 1'b0));
`endif
        exmem_wr = 0; memwb_wr = 0; id_valid = 0;
        tick("drain", 1'b1, none);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
